uart_rx: RTL

- Serial receiver that sits directly downstream of the team's UART transmitter. It consumes the serial line and recovers parallel words.
- Frame format, LSB first: start bit (0), DATA_WIDTH data bits, optional parity bit, one stop bit (1). Idle line is 1.
- Recovered words go to the fabric as a one-cycle rx_done strobe with registered data and error flags.
- Bit timing comes from the system clock by integer division. There is no oversampling clock.

---
 rtl/uart_pkg.sv | 45 ++++
 rtl/uart_rx_if.sv | 13 +
 rtl/uart_rx_sync.sv | 27 ++
 rtl/uart_rx.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, parity-mode constants,
// width helper and bit-timing expressions used by the receiver (and transmitter).
package uart_pkg;

  // FSM state encodings, shared with the transmitter
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_PARI  = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;
  localparam logic [2:0] ST_BREAK = 3'd6;

  // Parity mode is passed as a 4-character string; shorter names are
  // zero-padded on the left exactly as a string parameter would be.
  typedef logic [31:0] par_mode_t;
  localparam par_mode_t PAR_NONE = "NONE";
  localparam par_mode_t PAR_ODD  = {8'h00, "ODD"};
  localparam par_mode_t PAR_EVEN = "EVEN";

  // Ceiling log2, minimum 0 (v <= 1)
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((longint'(1) << i) < longint'(v)) r = i + 1;
    return r;
  endfunction

  // Clocks per bit by integer division
  function automatic int bit_period(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // Offset of the bit centre inside one bit period
  function automatic int half_period(input int clk_freq, input int baud_rate);
    return bit_period(clk_freq, baud_rate) / 2;
  endfunction

  // Any mode other than ODD/EVEN means no parity bit on the line
  function automatic bit par_enabled(input par_mode_t mode);
    return (mode == PAR_ODD) || (mode == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side result bundle: word, completion strobe, error flags and busy.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_done;
  logic                  rx_parity_err;
  logic                  rx_frame_err;
  logic                  rx_busy;

  modport master (output rx_data, rx_done, rx_parity_err, rx_frame_err, rx_busy);
  modport slave  (input  rx_data, rx_done, rx_parity_err, rx_frame_err, rx_busy);
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus a falling-edge
// detector on the synchronized value. All flops reset to the idle level (1).
module uart_rx_sync (
  input  logic clk,
  input  logic arstn,
  input  logic rxd,
  output logic rxd_s,
  output logic fall_pulse
);
  logic meta;
  logic rxd_d;

  // meta -> rxd_s is the synchronizer; rxd_d delays rxd_s for edge detection
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      meta  <= 1'b1;
      rxd_s <= 1'b1;
      rxd_d <= 1'b1;
    end else begin
      meta  <= rxd;
      rxd_s <= meta;
      rxd_d <= rxd_s;
    end
  end

  assign fall_pulse = rxd_d & ~rxd_s;
endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/optional parity/stop framing, LSB first, bit
// timing from integer division of the system clock (no oversampling clock).
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around each
// bit centre, decision one cycle later than the single-sample default.
module uart_rx
  import uart_pkg::*;
#(
  parameter int        CLK_FREQ   = 50_000_000,
  parameter int        BAUD_RATE  = 9600,
  parameter par_mode_t PARITY     = PAR_NONE,
  parameter int        DATA_WIDTH = 8
) (
  input  logic     clk,
  input  logic     arstn,
  input  logic     RXD,
  uart_rx_if.master rx
);
  localparam int N       = bit_period(CLK_FREQ, BAUD_RATE);
  localparam int HALF    = half_period(CLK_FREQ, BAUD_RATE);
  localparam int CW      = clog2(N);
  localparam int BW      = clog2(DATA_WIDTH + 1);
  localparam bit PAR_EN  = par_enabled(PARITY);
  localparam bit PAR_ODD_SEL = (PARITY == PAR_ODD);

  logic                  rxd_s;
  logic                  fall_pulse;
  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic [CW-1:0]         cnt;
  logic [BW-1:0]         bitcnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_err;
  logic                  sample_now;
  logic                  sample_bit;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  done_q;
  logic                  perr_q;
  logic                  ferr_q;

  uart_rx_sync u_sync (
    .clk        (clk),
    .arstn      (arstn),
    .rxd        (RXD),
    .rxd_s      (rxd_s),
    .fall_pulse (fall_pulse)
  );

`ifdef UART_RX_MAJORITY_EN
  logic maj_a;
  logic maj_b;

  // Capture the two samples preceding the decision point of each bit
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      maj_a <= 1'b1;
      maj_b <= 1'b1;
    end else begin
      if (cnt == CW'(HALF - 1)) maj_a <= rxd_s;
      if (cnt == CW'(HALF))     maj_b <= rxd_s;
    end
  end

  assign sample_now = (cnt == CW'(HALF + 1));
  assign sample_bit = (maj_a & maj_b) | (maj_a & rxd_s) | (maj_b & rxd_s);
`else
  assign sample_now = (cnt == CW'(HALF));
  assign sample_bit = rxd_s;
`endif

  // Frame sequencing; DONE re-arms straight into START on a coincident edge
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (fall_pulse) state_nxt = ST_START;
      ST_START: if (sample_now) state_nxt = sample_bit ? ST_IDLE : ST_SHIFT;
      ST_SHIFT: if (sample_now && bitcnt == BW'(DATA_WIDTH - 1))
                  state_nxt = PAR_EN ? ST_PARI : ST_STOP;
      ST_PARI:  if (sample_now) state_nxt = ST_STOP;
      ST_STOP:  if (sample_now) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ferr_q ? ST_BREAK : (fall_pulse ? ST_START : ST_IDLE);
      ST_BREAK: if (rxd_s) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Bit-period counter: cycle t0+j holds j mod N, so every sample lands on
  // the same count; parked at 0 whenever no frame is in flight
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn)                                             cnt <= '0;
    else if (state_nxt == ST_IDLE || state_nxt == ST_BREAK) cnt <= '0;
    else if (state == ST_IDLE || state == ST_DONE)          cnt <= CW'(1);
    else if (cnt == CW'(N - 1))                             cnt <= '0;
    else                                                    cnt <= cnt + CW'(1);
  end

  // Datapath: shift in data, check parity, publish the word at the stop sample
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      bitcnt  <= '0;
      shreg   <= '0;
      par_err <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_START: begin
          bitcnt  <= '0;
          par_err <= 1'b0;
        end
        ST_SHIFT: if (sample_now) begin
          shreg  <= {sample_bit, shreg[DATA_WIDTH-1:1]};
          bitcnt <= bitcnt + BW'(1);
        end
        ST_PARI: if (sample_now)
          par_err <= PAR_ODD_SEL ? ((~^shreg) != sample_bit) : ((^shreg) != sample_bit);
        ST_STOP: if (sample_now) begin
          data_q <= shreg;
          perr_q <= par_err;
          ferr_q <= ~sample_bit;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rx.rx_data       = data_q;
  assign rx.rx_done       = done_q;
  assign rx.rx_parity_err = perr_q;
  assign rx.rx_frame_err  = ferr_q;
  assign rx.rx_busy       = (state != ST_IDLE);
endmodule
